i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_line_sync.sv | 32 +++
 rtl/i2c_target.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// bit-counter width and the default bus address.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam int           BIT_CNT_W    = 4;
  localparam logic [6:0]   DEFAULT_ADDR = 7'h42;

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line through a preset-to-1 synchronizer, plus rise/fall strobes
// taken against the one-cycle-delayed synchronized value.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic line_in,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Preset to 1 so an idle (pulled-up) bus produces no edge out of reset.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign line_s = sync_q[STAGES-1];
  assign rise   = line_s & ~prev_q;
  assign fall   = ~line_s & prev_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target: byte writes surface on rx_data/rx_valid,
// reads pull bytes from tx_data on tx_req. No clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR    = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .line_in(scl),
    .line_s(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .line_in(sda),
    .line_s(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  wire start_det = sda_fall & scl_s;
  wire stop_det  = sda_rise & scl_s;

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [6:0]           shreg;   // 8th bit of a byte is taken straight from sda_s
  logic                 sda_oe;
  logic                 ack_drv;
  logic                 rw;

  // sda_oe is a flop cleared by the async reset, so the line lets go the
  // moment rst_n falls without passing through a combinational glitch.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      sda_oe   <= 1'b0;
      ack_drv  <= 1'b0;
      rw       <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (tx_req && state == RD_DATA) begin
        // tx_data is captured during the tx_req cycle; MSB goes out at once.
        shreg   <= tx_data[6:0];
        sda_oe  <= ~tx_data[7];
        bit_cnt <= BIT_CNT_W'(1);
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[5:0], sda_s};
            if (bit_cnt == BIT_CNT_W'(7)) begin
              bit_cnt <= '0;
              if (shreg == OWN_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= sda_s;
              end else begin
                state <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe  <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_drv <= 1'b0;
              bit_cnt <= '0;
              if (state == WR_ACK || !rw) begin
                state <= WR_DATA;
              end else begin
                state  <= RD_DATA;
                tx_req <= 1'b1;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg <= {shreg[5:0], sda_s};
            if (bit_cnt == BIT_CNT_W'(7)) begin
              rx_data  <= {shreg, sda_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              state    <= WR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == '0) begin
              tx_req <= 1'b1;   // first falling edge after a master ACK
            end else if (bit_cnt == BIT_CNT_W'(8)) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= RD_ACK;
            end else begin
              sda_oe  <= ~shreg[6];
              shreg   <= {shreg[5:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          RD_ACK: if (scl_rise) begin
            bit_cnt <= '0;
            state   <= sda_s ? IGNORE : RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
